stack_seq: RTL and testbench

Stack-operation sequencer for the 8085 core. It turns a single PUSH or POP request for a 16-bit word into the ordered stack-pointer strobes and byte-wide memory cycles needed to complete it. It drives the stack pointer's `en` / `en_read` / `inr_sp` controls and the memory strobe/data lines, and tracks stack depth to flag overflow and underflow. It sits between the instruction decoder (requester) and the stack pointer plus memory interface.

---
 rtl/stack_seq.sv | 165 ++++++++++++++++
 tb/tb_stack_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// stack_seq: PUSH/POP sequencer for the 8085 stack pointer and byte-wide memory.
// Define STACK_SEQ_WAIT_EN to make RD/WR states wait for mem_ready.
module stack_seq #(
    parameter int MAX_DEPTH = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        unf,
    output logic [7:0]  depth,
    output logic        sp_en,
    output logic        sp_en_read,
    output logic        sp_inr,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ready
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEC_H, S_WR_H, S_DEC_L, S_WR_L,
        S_RD_L, S_INC_L, S_RD_H, S_INC_H, S_DONE, S_REJ
    } state_t;

    state_t      state, nxt;
    logic [15:0] wdata_q, shadow;
    logic        mem_ok, full, empty, accept;
    logic        busy_n, done_n, ovf_n, unf_n;
    logic        en_n, er_n, inr_n, wr_n, rd_n;
    logic [7:0]  dout_n;

`ifdef STACK_SEQ_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_ready;
    assign unused_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    assign full   = (depth == MAX_DEPTH[7:0]);
    assign empty  = (depth == 8'd0);
    assign accept = (state == S_IDLE) && start
                    && !(op ? empty : full);

    always_comb begin
        nxt   = state;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                if (!op && full) begin
                    nxt   = S_REJ;
                    ovf_n = 1'b1;
                end else if (op && empty) begin
                    nxt   = S_REJ;
                    unf_n = 1'b1;
                end else begin
                    nxt = op ? S_RD_L : S_DEC_H;
                end
            end
            S_DEC_H: nxt = S_WR_H;
            S_WR_H:  nxt = mem_ok ? S_DEC_L : S_WR_H;
            S_DEC_L: nxt = S_WR_L;
            S_WR_L:  nxt = mem_ok ? S_DONE : S_WR_L;
            S_RD_L:  nxt = mem_ok ? S_INC_L : S_RD_L;
            S_INC_L: nxt = S_RD_H;
            S_RD_H:  nxt = mem_ok ? S_INC_H : S_RD_H;
            S_INC_H: nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            S_REJ:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered with it.
    always_comb begin
        busy_n = (nxt != S_IDLE);
        done_n = 1'b0;
        en_n   = 1'b0;
        er_n   = 1'b0;
        inr_n  = 1'b0;
        wr_n   = 1'b0;
        rd_n   = 1'b0;
        dout_n = 8'h00;
        unique case (nxt)
            S_DEC_H, S_DEC_L: begin
                en_n = 1'b1;
                er_n = 1'b1;
            end
            S_WR_H: begin
                en_n   = 1'b1;
                wr_n   = 1'b1;
                dout_n = accept ? wdata[15:8] : wdata_q[15:8];
            end
            S_WR_L: begin
                en_n   = 1'b1;
                wr_n   = 1'b1;
                dout_n = wdata_q[7:0];
            end
            S_RD_L, S_RD_H: begin
                en_n = 1'b1;
                rd_n = 1'b1;
            end
            S_INC_L, S_INC_H: begin
                en_n  = 1'b1;
                er_n  = 1'b1;
                inr_n = 1'b1;
            end
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wdata_q    <= 16'h0000;
            shadow     <= 16'h0000;
            rdata      <= 16'h0000;
            depth      <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            sp_en      <= 1'b0;
            sp_en_read <= 1'b0;
            sp_inr     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_dout   <= 8'h00;
        end else begin
            state      <= nxt;
            busy       <= busy_n;
            done       <= done_n;
            ovf        <= ovf_n;
            unf        <= unf_n;
            sp_en      <= en_n;
            sp_en_read <= er_n;
            sp_inr     <= inr_n;
            mem_wr     <= wr_n;
            mem_rd     <= rd_n;
            mem_dout   <= dout_n;
            if (accept)
                wdata_q <= wdata;
            if (state == S_RD_L && mem_ok)
                shadow[7:0] <= mem_din;
            if (state == S_RD_H && mem_ok)
                shadow[15:8] <= mem_din;
            if (state == S_WR_L && mem_ok)
                depth <= depth + 8'd1;
            if (state == S_INC_H) begin
                depth <= depth - 8'd1;
                rdata <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// Directed table-driven bench for stack_seq plus multi-cycle corner cases.
// Build with STACK_SEQ_WAIT_EN defined to exercise the memory wait path.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        reset, start, op, mem_ready;
    logic [15:0] wdata;
    logic [7:0]  mem_din;
    logic [15:0] rdata;
    logic        busy, done, ovf, unf;
    logic [7:0]  depth;
    logic        sp_en, sp_en_read, sp_inr, mem_wr, mem_rd;
    logic [7:0]  mem_dout;

    int nvec = 0;
    int nerr = 0;

`ifdef STACK_SEQ_WAIT_EN
    localparam int LAT = 8;
    localparam int WRC = 5;
`else
    localparam int LAT = 5;
    localparam int WRC = 2;
`endif

    always #5 clk = ~clk;

    stack_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .ovf(ovf), .unf(unf), .depth(depth), .sp_en(sp_en),
        .sp_en_read(sp_en_read), .sp_inr(sp_inr),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ready(mem_ready)
    );

    typedef struct {
        logic        start;
        logic        op;
        logic [15:0] wdata;
        logic [7:0]  din;
        logic [40:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic logic [40:0] pk(
        logic b, logic d, logic o, logic u, logic en, logic er,
        logic inr, logic wr, logic rd, logic [7:0] dout,
        logic [7:0] dep, logic [15:0] rd16);
        return {b, d, o, u, en, er, inr, wr, rd, dout, dep, rd16};
    endfunction

    function automatic logic [40:0] act();
        return {busy, done, ovf, unf, sp_en, sp_en_read, sp_inr,
                mem_wr, mem_rd, mem_dout, depth, rdata};
    endfunction

    task automatic add(logic s, logic o, logic [15:0] w,
                       logic [7:0] di, logic [40:0] e);
        vec_t v;
        v.start = s; v.op = o; v.wdata = w; v.din = di; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        int n;
        start = 1'b1; op = 1'b0; wdata = w;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        if (!done) chk("push_timeout", 64'(n), 64'd0);
        step();
    endtask

    initial begin
        int e, wrc;
        reset = 1'b1; start = 1'b0; op = 1'b0; wdata = 16'h0;
        mem_din = 8'h00; mem_ready = 1'b1;
        #1;
        chk("reset_state", 64'(act()), 64'd0);
        step(); step();
        reset = 1'b0;
        step();

        // PUSH 0xBEEF
        add(1, 0, 16'hBEEF, 8'h00, pk(1,0,0,0,1,1,0,0,0,8'h00,8'd0,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(1,0,0,0,1,0,0,1,0,8'hBE,8'd0,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(1,0,0,0,1,1,0,0,0,8'h00,8'd0,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(1,0,0,0,1,0,0,1,0,8'hEF,8'd0,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(1,1,0,0,0,0,0,0,0,8'h00,8'd1,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(0,0,0,0,0,0,0,0,0,8'h00,8'd1,16'h0));
        // POP: memory returns 0xEF then 0xBE
        add(1, 1, 16'h0000, 8'h00, pk(1,0,0,0,1,0,0,0,1,8'h00,8'd1,16'h0));
        add(0, 0, 16'h0000, 8'hEF, pk(1,0,0,0,1,1,1,0,0,8'h00,8'd1,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(1,0,0,0,1,0,0,0,1,8'h00,8'd1,16'h0));
        add(0, 0, 16'h0000, 8'hBE, pk(1,0,0,0,1,1,1,0,0,8'h00,8'd1,16'h0));
        add(0, 0, 16'h0000, 8'h00, pk(1,1,0,0,0,0,0,0,0,8'h00,8'd0,16'hBEEF));
        add(0, 0, 16'h0000, 8'h00, pk(0,0,0,0,0,0,0,0,0,8'h00,8'd0,16'hBEEF));
        // POP at depth 0 is rejected
        add(1, 1, 16'h0000, 8'h00, pk(1,0,0,1,0,0,0,0,0,8'h00,8'd0,16'hBEEF));
        add(0, 0, 16'h0000, 8'h00, pk(0,0,0,0,0,0,0,0,0,8'h00,8'd0,16'hBEEF));
        // PUSH 0x1234 with a stray start that must be ignored
        add(1, 0, 16'h1234, 8'h00, pk(1,0,0,0,1,1,0,0,0,8'h00,8'd0,16'hBEEF));
        add(1, 1, 16'hFFFF, 8'h00, pk(1,0,0,0,1,0,0,1,0,8'h12,8'd0,16'hBEEF));
        add(0, 0, 16'h0000, 8'h00, pk(1,0,0,0,1,1,0,0,0,8'h00,8'd0,16'hBEEF));
        add(0, 0, 16'h0000, 8'h00, pk(1,0,0,0,1,0,0,1,0,8'h34,8'd0,16'hBEEF));
        add(0, 0, 16'h0000, 8'h00, pk(1,1,0,0,0,0,0,0,0,8'h00,8'd1,16'hBEEF));
        add(0, 0, 16'h0000, 8'h00, pk(0,0,0,0,0,0,0,0,0,8'h00,8'd1,16'hBEEF));

        for (int i = 0; i < tv.size(); i++) begin
            start = tv[i].start; op = tv[i].op;
            wdata = tv[i].wdata; mem_din = tv[i].din;
            step();
            chk($sformatf("vec%0d", i), 64'(act()), 64'(tv[i].exp));
        end

        // Latency, wait states on WR_H and a mid-sequence start
        start = 1'b1; op = 1'b0; wdata = 16'hA55A;
        step();
        start = 1'b0;
        e = 1; wrc = 0;
        while (!done && e < 30) begin
            if (mem_wr) wrc++;
            if (e == 2) mem_ready = 1'b0;
            if (e == 3) begin start = 1'b1; op = 1'b1; end
            else start = 1'b0;
            if (e == 5) mem_ready = 1'b1;
            step();
            e++;
        end
        mem_ready = 1'b1;
        chk("wait_latency", 64'(e), 64'(LAT));
        chk("wait_wr_cycles", 64'(wrc), 64'(WRC));
        chk("wait_depth", 64'(depth), 64'd2);
        step();
        chk("wait_idle", 64'({busy, mem_rd}), 64'd0);

        // Fill to MAX_DEPTH, then overflow
        for (int k = 0; k < 200 && depth != 8'd125; k++)
            push_word(16'(k));
        chk("fill_depth", 64'(depth), 64'd125);
        start = 1'b1; op = 1'b0; wdata = 16'h7777;
        step();
        start = 1'b0;
        chk("ovf_pulse", 64'({busy, ovf, unf, sp_en, mem_wr}), 64'b11000);
        step();
        chk("ovf_after", 64'({busy, ovf}), 64'd0);
        chk("ovf_depth", 64'(depth), 64'd125);

        // Reset asserted during INC_L
        start = 1'b1; op = 1'b1; mem_din = 8'h11;
        step();
        start = 1'b0;
        step();
        chk("inc_l_reached", 64'({sp_en, sp_en_read, sp_inr}), 64'b111);
        reset = 1'b1;
        #1;
        chk("reset_mid", 64'(act()), 64'({1'b0, 24'h0, rdata}));
        chk("reset_depth", 64'(depth), 64'd0);
        step();
        reset = 1'b0;
        start = 1'b1; op = 1'b1;
        step();
        start = 1'b0;
        chk("post_reset_unf", 64'({busy, unf, mem_rd}), 64'b110);
        step();
        chk("post_reset_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
